// File: rtl/sifh_seq_pkg.sv
// ---------------------------------------------------------------------------
// sifh_seq_pkg
// Shared definitions for the SiFH two-pass frame sequencer.
//   seq_state_e        : sequencer FSM states
//   DEF_*_NUM          : default sizing (timestamps/pixel, pixels, acqs, bins)
//   PASS_COARSE/FINE   : encoding of the pass output
//   cw()               : counter width for a modulus, never below 1 bit
// ---------------------------------------------------------------------------
package sifh_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_ACQ      = 3'd2,
        ST_PASS_END = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_e;

    localparam int DEF_DATA_NUM  = 2;
    localparam int DEF_PIXEL_NUM = 200;
    localparam int DEF_ACQ_NUM   = 33333;
    localparam int DEF_BIN_NUM   = 1024;

    localparam logic PASS_COARSE = 1'b0;
    localparam logic PASS_FINE   = 1'b1;

    // A modulus of 1 still needs a 1-bit register to hold the constant 0.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sifh_wrap_cnt.sv
// ---------------------------------------------------------------------------
// sifh_wrap_cnt
// Modulo-N counter used for the sample, pixel, acquisition and clear-address
// indices of the frame sequencer.
// Ports:
//   clk      in   clock, rising edge
//   res      in   asynchronous active-low reset (count -> 0)
//   inc_i    in   advance by one this cycle
//   clr_i    in   synchronous return to 0 (wins over inc_i)
//   count_o  out  current count, 0..N-1
//   wrap_o   out  combinational: count is N-1 and inc_i is high, i.e. the
//                 counter returns to 0 at the coming edge; used as the carry
//                 into the next counter of a chain
// ---------------------------------------------------------------------------
module sifh_wrap_cnt #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         res,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] MAX = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_max;

    assign at_max = (count_q == MAX);
    assign wrap_o = inc_i & at_max;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = at_max ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sifh_frame_sequencer.sv
// ---------------------------------------------------------------------------
// sifh_frame_sequencer
// Control FSM of the two-pass SiFH histogram datapath. Pass 0 (coarse) and
// pass 1 (fine) each run: RAM clear sweep, timestamp acquisition, one
// pass-end cycle. Pass-end of the coarse pass pulses th_update; pass-end of
// the fine pass pulses result_valid, followed by one DONE cycle that pulses
// frame_done.
//
// Build option:
//   SIFH_AUTO_RESTART_EN  when defined, DONE loops straight back into the
//                         coarse clear sweep, so after the first start the
//                         sequencer never returns to IDLE.
//
// Ports:
//   clk           in   system clock, rising edge
//   res           in   asynchronous active-low reset
//   start         in   frame start request, only looked at in IDLE
//   in_valid      in   timestamp present from the TDC front-end
//   in_ready      out  timestamp accepted this cycle (ACQ only)
//   wr_en         out  histogram write strobe = in_valid & in_ready
//   data_idx      out  sample index of the timestamp being accepted
//   pix_idx       out  pixel index of the timestamp being accepted
//   acq_idx       out  acquisition index of the timestamp being accepted
//   pass          out  0 = coarse pass, 1 = fine pass
//   clr_en        out  RAM clear write strobe
//   clr_addr      out  RAM address being cleared
//   th_update     out  1-cycle pulse at the end of the coarse pass
//   result_valid  out  1-cycle pulse at the end of the fine pass
//   busy          out  high in every state except IDLE
//   frame_done    out  1-cycle pulse at the end of the frame
// ---------------------------------------------------------------------------
module sifh_frame_sequencer
    import sifh_seq_pkg::*;
#(
    parameter int DATA_NUM  = DEF_DATA_NUM,
    parameter int PIXEL_NUM = DEF_PIXEL_NUM,
    parameter int ACQ_NUM   = DEF_ACQ_NUM,
    parameter int BIN_NUM   = DEF_BIN_NUM
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      wr_en,
    output logic [cw(DATA_NUM)-1:0]   data_idx,
    output logic [cw(PIXEL_NUM)-1:0]  pix_idx,
    output logic [cw(ACQ_NUM)-1:0]    acq_idx,
    output logic                      pass,
    output logic                      clr_en,
    output logic [cw(BIN_NUM)-1:0]    clr_addr,
    output logic                      th_update,
    output logic                      result_valid,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int DW = cw(DATA_NUM);
    localparam int PW = cw(PIXEL_NUM);
    localparam int AW = cw(ACQ_NUM);
    localparam int CW = cw(BIN_NUM);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       pass_q;
    logic       pass_d;

    logic       data_wrap;
    logic       pix_wrap;
    logic       acq_wrap;
    logic       clr_wrap;
    logic       cnt_park;

    // Strobes that feed the counters come straight from the state register,
    // keeping the counter wrap outputs free of any path back through the
    // next-state logic.
    assign in_ready = (state_q == ST_ACQ);
    assign wr_en    = in_valid & in_ready;
    assign clr_en   = (state_q == ST_CLEAR);
    assign busy     = (state_q != ST_IDLE);
    assign pass     = pass_q;

    // All counters wrap back to 0 on their own at the end of every sweep;
    // holding them at 0 in IDLE just guarantees a clean start.
    assign cnt_park = (state_q == ST_IDLE);

    // Index chain: sample carries into pixel, pixel carries into acquisition.
    // The acquisition wrap is therefore the final accept of the pass.
    sifh_wrap_cnt #(.N(DATA_NUM), .W(DW)) u_data_cnt (
        .clk     (clk),
        .res     (res),
        .inc_i   (wr_en),
        .clr_i   (cnt_park),
        .count_o (data_idx),
        .wrap_o  (data_wrap)
    );

    sifh_wrap_cnt #(.N(PIXEL_NUM), .W(PW)) u_pix_cnt (
        .clk     (clk),
        .res     (res),
        .inc_i   (data_wrap),
        .clr_i   (cnt_park),
        .count_o (pix_idx),
        .wrap_o  (pix_wrap)
    );

    sifh_wrap_cnt #(.N(ACQ_NUM), .W(AW)) u_acq_cnt (
        .clk     (clk),
        .res     (res),
        .inc_i   (pix_wrap),
        .clr_i   (cnt_park),
        .count_o (acq_idx),
        .wrap_o  (acq_wrap)
    );

    sifh_wrap_cnt #(.N(BIN_NUM), .W(CW)) u_clr_cnt (
        .clk     (clk),
        .res     (res),
        .inc_i   (clr_en),
        .clr_i   (cnt_park),
        .count_o (clr_addr),
        .wrap_o  (clr_wrap)
    );

    // Next-state and inter-pass pulses. PASS_END and DONE each last exactly
    // one cycle, so th_update/result_valid/frame_done are single-cycle pulses
    // that can never overlap wr_en (ACQ) or clr_en (CLEAR).
    always_comb begin
        state_d      = state_q;
        pass_d       = pass_q;
        th_update    = 1'b0;
        result_valid = 1'b0;
        frame_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    pass_d  = PASS_COARSE;
                end
            end
            ST_CLEAR: begin
                if (clr_wrap) begin
                    state_d = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (acq_wrap) begin
                    state_d = ST_PASS_END;
                end
            end
            ST_PASS_END: begin
                if (pass_q == PASS_COARSE) begin
                    th_update = 1'b1;
                    pass_d    = PASS_FINE;
                    state_d   = ST_CLEAR;
                end else begin
                    result_valid = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                pass_d     = PASS_COARSE;
`ifdef SIFH_AUTO_RESTART_EN
                state_d    = ST_CLEAR;
`else
                state_d    = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                pass_d  = PASS_COARSE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            pass_q  <= PASS_COARSE;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

endmodule

// File: tb/tb_sifh_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sifh_frame_sequencer
// Bench for sifh_frame_sequencer at DATA_NUM=2, PIXEL_NUM=3, ACQ_NUM=2,
// BIN_NUM=4. A phase/count model predicts every output each cycle; indices
// are derived arithmetically from the number of samples accepted in the pass.
// Directed frames: an aborted frame (reset in the fine pass), a frame with an
// input gap and a stray start, and a gap-free frame; frame-level results are
// pinned with literal values.
// ---------------------------------------------------------------------------
module tb_sifh_frame_sequencer;

    localparam int D = 2;
    localparam int P = 3;
    localparam int A = 2;
    localparam int B = 4;
    localparam int N = D * P * A;

    logic       clk = 1'b0;
    logic       res;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       wr_en;
    logic [0:0] data_idx;
    logic [1:0] pix_idx;
    logic [0:0] acq_idx;
    logic       pass;
    logic       clr_en;
    logic [1:0] clr_addr;
    logic       th_update;
    logic       result_valid;
    logic       busy;
    logic       frame_done;

    sifh_frame_sequencer #(
        .DATA_NUM  (D),
        .PIXEL_NUM (P),
        .ACQ_NUM   (A),
        .BIN_NUM   (B)
    ) dut (
        .clk          (clk),
        .res          (res),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .data_idx     (data_idx),
        .pix_idx      (pix_idx),
        .acq_idx      (acq_idx),
        .pass         (pass),
        .clr_en       (clr_en),
        .clr_addr     (clr_addr),
        .th_update    (th_update),
        .result_valid (result_valid),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_CLR, M_ACQ, M_END, M_DONE} mph_e;
    mph_e m_ph;
    int   m_c;   // clear sweep position
    int   m_k;   // samples accepted so far in this pass
    int   m_p;   // pass

    always @(posedge clk or negedge res) begin
        if (!res) begin
            m_ph <= M_IDLE; m_c <= 0; m_k <= 0; m_p <= 0;
        end else begin
            case (m_ph)
                M_IDLE: if (start) begin m_ph <= M_CLR; m_c <= 0; m_p <= 0; end
                M_CLR: begin
                    if (m_c == B - 1) begin m_ph <= M_ACQ; m_k <= 0; m_c <= 0; end
                    else m_c <= m_c + 1;
                end
                M_ACQ: begin
                    if (in_valid) begin
                        if (m_k == N - 1) begin m_ph <= M_END; m_k <= 0; end
                        else m_k <= m_k + 1;
                    end
                end
                M_END: begin
                    if (m_p == 0) begin m_p <= 1; m_ph <= M_CLR; m_c <= 0; end
                    else m_ph <= M_DONE;
                end
                M_DONE: begin
                    m_p <= 0;
`ifdef SIFH_AUTO_RESTART_EN
                    m_ph <= M_CLR; m_c <= 0;
`else
                    m_ph <= M_IDLE;
`endif
                end
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare + trace recording ----------------
    int clr_q[$];
    int seq_q[$];
    int th_cnt;
    int rv_cnt;

    always @(negedge clk) begin
        chk("busy",         busy,         m_ph != M_IDLE);
        chk("in_ready",     in_ready,     m_ph == M_ACQ);
        chk("wr_en",        wr_en,        (m_ph == M_ACQ) && in_valid);
        chk("data_idx",     data_idx,     (m_ph == M_ACQ) ? m_k % D : 0);
        chk("pix_idx",      pix_idx,      (m_ph == M_ACQ) ? (m_k / D) % P : 0);
        chk("acq_idx",      acq_idx,      (m_ph == M_ACQ) ? m_k / (D * P) : 0);
        chk("pass",         pass,         m_p);
        chk("clr_en",       clr_en,       m_ph == M_CLR);
        chk("clr_addr",     clr_addr,     (m_ph == M_CLR) ? m_c : 0);
        chk("th_update",    th_update,    (m_ph == M_END) && (m_p == 0));
        chk("result_valid", result_valid, (m_ph == M_END) && (m_p == 1));
        chk("frame_done",   frame_done,   m_ph == M_DONE);
        if (clr_en) clr_q.push_back(int'(clr_addr));
        if (wr_en && !pass) seq_q.push_back(int'(acq_idx) * 8 + int'(pix_idx) * 2 + int'(data_idx));
        if (th_update)    th_cnt++;
        if (result_valid) rv_cnt++;
    end

    // ---------------- hand-computed expectations ----------------
    // Coarse-pass accept order packed as acq*8 + pix*2 + data:
    // (0,0,0)(1,0,0)(0,1,0)(1,1,0)(0,2,0)(1,2,0)(0,0,1)...(1,2,1)
    int exp_seq[12] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13};
    int exp_clr[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int gaps;

    task automatic clear_traces();
        clr_q.delete();
        seq_q.delete();
        th_cnt = 0;
        rv_cnt = 0;
        gaps   = 0;
    endtask

    // Run from the cycle after the start edge until frame_done. With inject
    // set: 3 idle in_valid cycles after accept #5 and a start pulse during
    // the fine pass. Returns the cycle number at which frame_done was seen.
    task automatic run_frame(input bit inject, output int n);
        int acc;
        int g;
        bit st;
        bit got;
        acc = 0; g = 0; st = 1'b0; got = 1'b0; n = 0;
        clear_traces();
        while (n < 500) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("first_cycle_clr_en", clr_en, 1);
                chk("first_cycle_pass",   pass,   0);
                chk("first_cycle_busy",   busy,   1);
            end
            if (frame_done) begin
                got = 1'b1;
                break;
            end
            if (!in_valid) begin
                chk("gap_data_idx", data_idx, 1);
                chk("gap_pix_idx",  pix_idx,  2);
                chk("gap_acq_idx",  acq_idx,  0);
                chk("gap_wr_en",    wr_en,    0);
                gaps++;
            end
            if (wr_en) begin
                acc++;
                if (inject && acc == 5)     g  = 3;
                if (inject && acc == N + 3) st = 1'b1;
            end
            @(posedge clk);
            #2;
            in_valid = (g == 0);
            if (g > 0) g--;
            start = st;
            st    = 1'b0;
        end
        chk("frame_done_seen", got, 1);
    endtask

    task automatic check_frame(input string tag, input int n, input int exp_lat, input int exp_gaps);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_th_pulses"}, th_cnt, 1);
        chk({tag, "_rv_pulses"}, rv_cnt, 1);
        chk({tag, "_gap_cycles"}, gaps, exp_gaps);
        chk({tag, "_clr_len"}, clr_q.size(), 8);
        foreach (exp_clr[i])
            chk($sformatf("%s_clr_%0d", tag, i), (i < clr_q.size()) ? clr_q[i] : -1, exp_clr[i]);
        chk({tag, "_coarse_len"}, seq_q.size(), 12);
        foreach (exp_seq[i])
            chk($sformatf("%s_coarse_%0d", tag, i), (i < seq_q.size()) ? seq_q[i] : -1, exp_seq[i]);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"},     busy,     0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_en"},    wr_en,    0);
        chk({tag, "_clr_en"},   clr_en,   0);
        chk({tag, "_pass"},     pass,     0);
        chk({tag, "_data_idx"}, data_idx, 0);
        chk({tag, "_pix_idx"},  pix_idx,  0);
        chk({tag, "_acq_idx"},  acq_idx,  0);
        chk({tag, "_clr_addr"}, clr_addr, 0);
        chk({tag, "_rv"},       result_valid, 0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int cnt;
        res = 1'b1; start = 1'b0; in_valid = 1'b0;
        #1 res = 1'b0;
        repeat (2) begin
            @(posedge clk); #2;
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
        end
        #1 reset_checks("por");
        @(posedge clk); #2;
        start = 1'b0; in_valid = 1'b1; res = 1'b1;
        @(negedge clk);
        chk("idle_after_por", busy, 0);

        // Frame 1: aborted by reset three accepts into the fine pass.
        clear_traces();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        cnt = 0; n = 0;
        while (cnt < 3 && n < 300) begin
            @(negedge clk);
            n++;
            if (pass && wr_en) cnt++;
        end
        chk("abort_reached_fine", cnt, 3);
        @(posedge clk); #2;
        res      = 1'b0;
        start    = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        #1 reset_checks("abort");
        @(posedge clk); #2;
        res = 1'b1; start = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        chk("abort_th_pulses", th_cnt, 1);
        chk("abort_rv_pulses", rv_cnt, 0);

        // Frame 2: gap after accept #5, stray start in the fine pass.
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        run_frame(1'b1, n);
        check_frame("f2", n, 38, 3);

        // Frame 3: no gaps; 2*(4+12+1)+1 = 35 cycles.
`ifndef SIFH_AUTO_RESTART_EN
        @(negedge clk);
        chk("post_done_busy",   busy,   0);
        chk("post_done_clr_en", clr_en, 0);
        repeat (2) @(negedge clk);
        chk("stay_idle_busy", busy, 0);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
`endif
        run_frame(1'b0, n);
        check_frame("f3", n, 35, 0);

        repeat (4) @(negedge clk);
`ifdef SIFH_AUTO_RESTART_EN
        chk("auto_still_busy", busy, 1);
`else
        chk("final_idle", busy, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sifh_frame_sequencer.md
Name: sifh_frame_sequencer

Overview:
- Control FSM for the two-pass SiFH histogram datapath: pass 0 builds the coarse histogram, pass 1 builds the fine (windowed) histogram.
- Accepts timestamps from the TDC front-end through a valid/ready handshake.
- Generates the write strobe and the sample/pixel/acquisition indices for the histogram RAM.
- Sequences the RAM clear sweep before each pass, plus the threshold-update and result-latch pulses between passes.
- Sits between the data filterer/TDC interface and the histogram builder/peak detector.

Parameters:
- DATA_NUM, 2, timestamps per pixel per acquisition.
- PIXEL_NUM, 200, pixels sharing one histogram RAM.
- ACQ_NUM, 33333, acquisitions per pass.
- BIN_NUM, 1024, RAM words to clear (bins per RAM).
- Counter widths are $clog2 of the matching parameter, minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous active-low reset.
- start  in  1  frame start request, level-sampled; honoured only in IDLE.
- in_valid  in  1  timestamp present from front-end.
- in_ready  out  1  sequencer accepts timestamp this cycle.
- wr_en  out  1  histogram write strobe (= in_valid & in_ready).
- data_idx  out  $clog2(DATA_NUM)  sample index of the current accepted timestamp.
- pix_idx  out  $clog2(PIXEL_NUM)  pixel index of the current accepted timestamp.
- acq_idx  out  $clog2(ACQ_NUM)  acquisition index.
- pass  out  1  0 = coarse pass, 1 = fine pass.
- clr_en  out  1  RAM clear write strobe.
- clr_addr  out  $clog2(BIN_NUM)  RAM address being cleared.
- th_update  out  1  1-cycle pulse: peak detector loads new thresholds from coarse result.
- result_valid  out  1  1-cycle pulse: peak detector latches fine result.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  1-cycle pulse at end of frame.

Behaviour:
- Reset (res low, asynchronous): FSM to IDLE; all counters, pass, clr_addr and pulse outputs go to 0; in_ready=0, busy=0.
- States: IDLE, CLEAR, ACQ, PASS_END, DONE. All state transitions are registered.
- IDLE:
  - start=1 → CLEAR with pass=0.
  - Inputs other than start are ignored.
- CLEAR:
  - clr_en=1 for exactly BIN_NUM cycles; clr_addr = 0..BIN_NUM-1.
  - After the cycle with clr_addr=BIN_NUM-1 → ACQ; clr_addr returns to 0.
  - in_ready=0 throughout.
- ACQ:
  - in_ready=1.
  - On each accepted sample (wr_en), the index outputs show that sample's position; counters then advance at the clock edge.
  - Advance order: data_idx wraps DATA_NUM-1→0 and carries to pix_idx; pix_idx wraps PIXEL_NUM-1→0 and carries to acq_idx.
  - in_valid low: nothing advances (gaps allowed anywhere).
  - Final accept (all three indices at max) → PASS_END next cycle; all indices return to 0; in_ready drops the next cycle.
- PASS_END (1 cycle):
  - pass=0: th_update=1, pass←1, → CLEAR.
  - pass=1: result_valid=1, → DONE.
- DONE (1 cycle): frame_done=1, pass←0, → IDLE. busy falls the cycle after DONE.
- Per-frame latency with no input gaps: 2·(BIN_NUM + DATA_NUM·PIXEL_NUM·ACQ_NUM + 1) + 1 cycles from start sampled to frame_done.
- start while busy: ignored; no queuing.
- th_update and result_valid never coincide; neither coincides with wr_en or clr_en.
- Reset mid-pass aborts immediately. No partial-result pulse is emitted. The next start reruns the full sequence from the CLEAR of pass 0.

Optional Feature:
- Macro: SIFH_AUTO_RESTART_EN.
- Defined:
  - DONE goes directly to CLEAR with pass=0; frame_done still pulses.
  - busy stays high continuously; start only launches the first frame after reset.
- Undefined: DONE → IDLE; each frame requires start.

Decomposition:
- Package sifh_seq_pkg:
  - state enum (IDLE, CLEAR, ACQ, PASS_END, DONE);
  - default parameter constants DATA_NUM/PIXEL_NUM/ACQ_NUM/BIN_NUM;
  - pass encoding constants PASS_COARSE=0, PASS_FINE=1.
- Sub-module sifh_wrap_cnt:
  - parameterised modulo counter with inputs inc/clr, outputs count and a combinational wrap (at max & inc).
  - Instantiated four times: data, pixel, acquisition, clear address.

Test Plan (DATA_NUM=2, PIXEL_NUM=3, ACQ_NUM=2, BIN_NUM=4):
1. Assert res low mid-cycle with random inputs → immediately busy=0, in_ready=0, clr_en=0, pass=0, all indices 0; after release, state IDLE.
2. Pulse start → busy=1 next cycle; clr_en=1 for 4 cycles with clr_addr 0,1,2,3; then in_ready=1, pass=0.
3. in_valid held high for coarse pass → 12 accepts; (data,pix,acq) sequence (0,0,0),(1,0,0),(0,1,0)…(1,2,1); th_update single pulse the cycle after the 12th accept; pass=1; then a 4-cycle clear sweep.
4. Insert in_valid=0 for 3 cycles after accept #5 → indices frozen at (1,2,0) during the gap; wr_en=0; the sequence resumes unchanged.
5. Complete fine pass → result_valid pulse, then frame_done pulse the following cycle, then busy=0. A start pulse during ACQ is ignored (no restart, indices unaffected).
6. With SIFH_AUTO_RESTART_EN defined: after frame_done, clr_en rises the next cycle with pass=0 and start held low; busy never drops. Undefined: stays IDLE.
